// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with zero and parity flags.
// Stage 1 holds operands and select; stage 2 holds the registered result and flags.
module logic_unit_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Ai,
   input  logic [WIDTH-1:0] Bi,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Ei,
   output logic             zero,
   output logic             parity
);

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [2:0]       sel_r;
   logic             s1_valid_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] ei_r;
   logic             zero_r;
   logic             parity_r;

   logic             s2_free_s;
   logic             s1_adv_s;
   logic             in_ready_s;
   logic             in_fire_s;
   logic [WIDTH-1:0] result_s;

   function automatic logic [WIDTH-1:0] op_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       s);
      logic [WIDTH-1:0] r;
      case (s)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~a;
         3'b100:  r = ~(a & b);
         3'b101:  r = ~(a | b);
         3'b110:  r = ~(a ^ b);
         3'b111:  r = b;
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   function automatic logic parity_f(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Handshake control; in_ready is combinational from out_ready by design.
   always_comb begin
      s2_free_s  = !out_valid_r || out_ready;
      s1_adv_s   = s1_valid_r && s2_free_s;
      in_ready_s = !s1_valid_r || s2_free_s;
      in_fire_s  = in_valid && in_ready_s;
      result_s   = op_f(a_r, b_r, sel_r);
   end

   // Stage 1: operand capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         a_r        <= {WIDTH{1'b0}};
         b_r        <= {WIDTH{1'b0}};
         sel_r      <= 3'b000;
      end else begin
         if (flush) begin
            s1_valid_r <= 1'b0;
         end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
         end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
         end else begin
            s1_valid_r <= s1_valid_r;
         end
         if (in_fire_s && !flush) begin
            a_r   <= Ai;
            b_r   <= Bi;
            sel_r <= sel;
         end
      end
   end

   // Stage 2: result and flags; held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         ei_r        <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         parity_r    <= 1'b0;
      end else begin
         if (flush) begin
            out_valid_r <= 1'b0;
         end else if (s1_adv_s) begin
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= out_valid_r && !out_ready;
         end
         if (s1_adv_s && !flush) begin
            ei_r     <= result_s;
            zero_r   <= (result_s == {WIDTH{1'b0}});
            parity_r <= parity_f(result_s);
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign Ei        = ei_r;
   assign zero      = zero_r;
   assign parity    = parity_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=32 and WIDTH=1 instances).
module tb_logic_unit_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, zero, parity;
   logic [31:0] Ai = 32'h0, Bi = 32'h0, Ei;
   logic [2:0]  sel = 3'b000;

   logic        flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b1;
   logic        in_ready1, out_valid1, zero1, parity1;
   logic [0:0]  a1 = 1'b0, b1 = 1'b0, e1;
   logic [2:0]  sel1 = 3'b000;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .Ai(Ai), .Bi(Bi), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .Ei(Ei), .zero(zero), .parity(parity));

   logic_unit_pipe #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
      .Ai(a1), .Bi(b1), .sel(sel1), .out_valid(out_valid1), .out_ready(out_ready1),
      .Ei(e1), .zero(zero1), .parity(parity1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // power-on reset state
      #1;
      checks++; if ({out_valid, in_ready, Ei, zero, parity} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_idle: ov=%b ir=%b Ei=%h z=%b p=%b want 0 1 0 0 0", out_valid, in_ready, Ei, zero, parity);
      end
      checks++; if ({out_valid1, in_ready1} !== 2'b01) begin
         errors++; $display("FAIL reset_idle_w1: ov=%b ir=%b want 0 1", out_valid1, in_ready1);
      end
      tick(); rst = 1'b0; tick();
      // fill both stages with the consumer stalled
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'b111; Bi = 32'h0000_0055;
      tick(); Bi = 32'h0000_0066;
      tick(); in_valid = 1'b0;
      #1;
      checks++; if ({out_valid, in_ready, Ei} !== {1'b1, 1'b0, 32'h0000_0055}) begin
         errors++; $display("FAIL reset_prefill: ov=%b ir=%b Ei=%h want 1 0 00000055", out_valid, in_ready, Ei);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if ({out_valid, in_ready, Ei, zero, parity} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_midstream: ov=%b ir=%b Ei=%h z=%b p=%b want 0 1 0 0 0", out_valid, in_ready, Ei, zero, parity);
      end
      #1 rst = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_dropped: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_all_ops();
      logic [31:0] exp [8];
      exp = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h0F0F_EDCB,
              32'hFF0F_EDCB, 32'h000F_0000, 32'h00FF_1234, 32'h0FF0_FFFF};
      Ai = 32'hF0F0_1234; Bi = 32'h0FF0_FFFF; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 8);
         sel = 3'(i);
         tick();
         checks++; if (out_valid !== ((i >= 1) && (i <= 8))) begin
            errors++; $display("FAIL ops_valid[%0d]: got %b want %b", i, out_valid, (i >= 1) && (i <= 8));
         end
         if ((i >= 1) && (i <= 8)) begin
            checks++; if ({Ei, zero} !== {exp[i-1], 1'b0}) begin
               errors++; $display("FAIL ops_sel%0d: Ei=%h z=%b want %h 0", i - 1, Ei, zero, exp[i-1]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flags();
      out_ready = 1'b1; in_valid = 1'b1;
      sel = 3'b000; Ai = 32'hAAAA_AAAA; Bi = 32'h5555_5555;
      tick();
      sel = 3'b111; Ai = 32'hFFFF_FFFF; Bi = 32'h0000_0007;
      tick();
      in_valid = 1'b0;
      checks++; if ({out_valid, Ei, zero, parity} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL flags_and: ov=%b Ei=%h z=%b p=%b want 1 0 1 0", out_valid, Ei, zero, parity);
      end
      tick();
      checks++; if ({out_valid, Ei, zero, parity} !== {1'b1, 32'h7, 1'b0, 1'b1}) begin
         errors++; $display("FAIL flags_pass: ov=%b Ei=%h z=%b p=%b want 1 7 0 1", out_valid, Ei, zero, parity);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int recv = 0;
      logic exp_ir;
      sel = 3'b111; Ai = 32'h0;
      for (int c = 0; c < 14; c++) begin
         out_ready = !((c >= 2) && (c <= 5));
         in_valid  = (sent < 5);
         Bi        = 32'h100 + 32'(sent);
         #1;
         exp_ir = !((c >= 2) && (c <= 5));
         checks++; if (in_ready !== exp_ir) begin
            errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, exp_ir);
         end
         if ((c >= 3) && (c <= 5)) begin
            checks++; if ({out_valid, Ei} !== {1'b1, 32'h100}) begin
               errors++; $display("FAIL bp_hold[%0d]: ov=%b Ei=%h want 1 00000100", c, out_valid, Ei);
            end
         end
         if (out_valid && out_ready) begin
            checks++; if (Ei !== 32'h100 + 32'(recv)) begin
               errors++; $display("FAIL bp_order[%0d]: Ei=%h want %h", recv, Ei, 32'h100 + 32'(recv));
            end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0;
      checks++; if ((sent != 5) || (recv != 5) || (out_valid !== 1'b0)) begin
         errors++; $display("FAIL bp_count: sent=%0d recv=%0d ov=%b want 5 5 0", sent, recv, out_valid);
      end
   endtask

   task automatic test_flush();
      sel = 3'b111; out_ready = 1'b0; in_valid = 1'b1;
      Bi = 32'h200; tick();
      Bi = 32'h201; tick();
      flush = 1'b1; out_ready = 1'b1; Bi = 32'h2FF;
      #1;
      checks++; if ({out_valid, in_ready} !== 2'b11) begin
         errors++; $display("FAIL flush_stall_rule: ov=%b ir=%b want 1 1", out_valid, in_ready);
      end
      tick();
      flush = 1'b0; Bi = 32'h203;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_clear: ov=%b want 0", out_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_discard: ov=%b Ei=%h want ov 0", out_valid, Ei);
      end
      tick();
      checks++; if ({out_valid, Ei} !== {1'b1, 32'h203}) begin
         errors++; $display("FAIL flush_next: ov=%b Ei=%h want 1 00000203", out_valid, Ei);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_drain: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_width1();
      // bit (sel*4 + a*2 + b): AND, OR, XOR, NOT Ai truth tables
      logic [15:0] tt;
      logic        e;
      tt = 16'b0011_0110_1110_1000;
      out_ready1 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_valid1 = (i < 16);
         sel1 = 3'((i >> 2) & 3);
         a1   = 1'((i >> 1) & 1);
         b1   = 1'(i & 1);
         tick();
         checks++; if (out_valid1 !== ((i >= 1) && (i <= 16))) begin
            errors++; $display("FAIL w1_valid[%0d]: got %b want %b", i, out_valid1, (i >= 1) && (i <= 16));
         end
         if ((i >= 1) && (i <= 16)) begin
            e = tt[i-1];
            checks++; if ({e1, zero1, parity1} !== {e, ~e, e}) begin
               errors++; $display("FAIL w1_vec%0d: E=%b z=%b p=%b want %b %b %b", i - 1, e1, zero1, parity1, e, ~e, e);
            end
         end
      end
      in_valid1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_all_ops();
      test_flags();
      test_backpressure();
      test_flush();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
